// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame decoder: control codes,
// bin geometry, error classes and the FSM state encodings.
package uart_frame_pkg;

    localparam int DATA_W     = 22;
    localparam int GROUP_W    = 7;
    localparam int MAX_GROUPS = 4;

    localparam logic [7:0] CTRL_FRAME_START = 8'h80;
    localparam logic [7:0] CTRL_FRAME_END   = 8'h81;
    localparam logic [7:0] CTRL_BIN_START   = 8'h82;
    localparam logic [7:0] CTRL_BIN_END     = 8'h83;

    typedef enum logic [1:0] {
        ERR_FRAMING  = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_PROTOCOL = 2'd2
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_BIN   = 2'd2
    } dec_state_t;

    typedef enum logic [2:0] {
        RX_WAIT_HIGH = 3'd0,
        RX_IDLE      = 3'd1,
        RX_START     = 3'd2,
        RX_DATA      = 3'd3,
        RX_STOP      = 3'd4
    } rx_state_t;

    // ORs a 7-bit payload into slot idx of the bin value; bits above DATA_W fall off.
    function automatic logic [DATA_W-1:0] place_group(
        input logic [DATA_W-1:0]  acc,
        input logic [GROUP_W-1:0] payload,
        input logic [2:0]         idx
    );
        logic [DATA_W+GROUP_W-1:0] wide;
        wide = {{GROUP_W{1'b0}}, acc} |
               ({{DATA_W{1'b0}}, payload} << (GROUP_W * int'(idx)));
        return wide[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronises the line, detects start on a falling edge,
// samples mid-bit and flags a low stop bit as a framing error.
module uart_rx_byte
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic [7:0] o_byte
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;
    logic [7:0]       r_byte;

    rx_state_t        w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [2:0]       w_bit;
    logic [7:0]       w_shift;
    logic             w_byte_valid;
    logic             w_frame_err;
    logic [7:0]       w_byte;
    logic             w_fall;

    // Synchroniser resets low so a line held low across reset cannot look like idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev & ~r_sync2;

    // Receiver state and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= RX_WAIT_HIGH;
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte       <= 8'h00;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_bit        <= w_bit;
            r_shift      <= w_shift;
            r_byte_valid <= w_byte_valid;
            r_frame_err  <= w_frame_err;
            r_byte       <= w_byte;
        end
    end

    // Bit-timing state machine: next state and strobes.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_bit        = r_bit;
        w_shift      = r_shift;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        w_byte       = r_byte;
        case (r_state)
            RX_WAIT_HIGH: begin
                if (r_sync2) w_state = RX_IDLE;
                else         w_state = RX_WAIT_HIGH;
            end
            RX_IDLE: begin
                if (w_fall) begin
                    w_state = RX_START;
                    w_cnt   = '0;
                end else begin
                    w_state = RX_IDLE;
                end
            end
            RX_START: begin
                if (r_cnt == HALF_TICK) begin
                    w_cnt = '0;
                    w_bit = 3'd0;
                    if (!r_sync2) w_state = RX_DATA;
                    else          w_state = RX_IDLE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == LAST_TICK) begin
                    w_cnt   = '0;
                    w_shift = {r_sync2, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state = RX_STOP;
                    else               w_bit   = r_bit + 3'd1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_cnt == LAST_TICK) begin
                    w_cnt   = '0;
                    w_state = RX_IDLE;
                    if (r_sync2) begin
                        w_byte_valid = 1'b1;
                        w_byte       = r_shift;
                    end else begin
                        w_frame_err  = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = RX_WAIT_HIGH;
            end
        endcase
    end

    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;
    assign o_byte       = r_byte;

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame/bin protocol decoder on top of an 8N1 byte receiver: assembles
// 7-bit data groups into 22-bit bins and reports frame boundaries and errors.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int BIN_CNT_W    = 10
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic                 o_frame_start,
    output logic                 o_frame_end,
    output logic [BIN_CNT_W-1:0] o_frame_bins,
    output logic                 o_bin_valid,
    output logic [DATA_W-1:0]    o_bin_data,
    output logic [BIN_CNT_W-1:0] o_bin_index,
    output logic                 o_error,
    output logic [1:0]           o_error_code
);

    logic       w_rx_valid;
    logic       w_rx_err;
    logic [7:0] w_rx_byte;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk        (sys_clock),
        .i_rst        (reset),
        .i_rx         (UART_RX),
        .o_byte_valid (w_rx_valid),
        .o_frame_err  (w_rx_err),
        .o_byte       (w_rx_byte)
    );

    dec_state_t           r_state,       w_state;
    logic [BIN_CNT_W-1:0] r_bin_cnt,     w_bin_cnt;
    logic [DATA_W-1:0]    r_acc,         w_acc;
    logic [2:0]           r_groups,      w_groups;
    logic                 r_frame_start, w_frame_start;
    logic                 r_frame_end,   w_frame_end;
    logic [BIN_CNT_W-1:0] r_frame_bins,  w_frame_bins;
    logic                 r_bin_valid,   w_bin_valid;
    logic [DATA_W-1:0]    r_bin_data,    w_bin_data;
    logic [BIN_CNT_W-1:0] r_bin_index,   w_bin_index;
    logic                 r_error,       w_error;
    logic [1:0]           r_error_code,  w_error_code;
    logic                 w_overflow;

    // Decoder state and registered outputs.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bin_cnt     <= '0;
            r_acc         <= '0;
            r_groups      <= 3'd0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_bins  <= '0;
            r_bin_valid   <= 1'b0;
            r_bin_data    <= '0;
            r_bin_index   <= '0;
            r_error       <= 1'b0;
            r_error_code  <= 2'd0;
        end else begin
            r_state       <= w_state;
            r_bin_cnt     <= w_bin_cnt;
            r_acc         <= w_acc;
            r_groups      <= w_groups;
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_frame_bins  <= w_frame_bins;
            r_bin_valid   <= w_bin_valid;
            r_bin_data    <= w_bin_data;
            r_bin_index   <= w_bin_index;
            r_error       <= w_error;
            r_error_code  <= w_error_code;
        end
    end

    // A fifth group, or a fourth group wider than the single bit left, overflows.
    assign w_overflow = (r_groups == 3'(MAX_GROUPS)) ||
                        ((r_groups == 3'(MAX_GROUPS - 1)) && (w_rx_byte[6:0] > 7'd1));

    // Protocol state machine: next state and output values per received byte.
    always_comb begin
        w_state       = r_state;
        w_bin_cnt     = r_bin_cnt;
        w_acc         = r_acc;
        w_groups      = r_groups;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_frame_bins  = r_frame_bins;
        w_bin_valid   = 1'b0;
        w_bin_data    = r_bin_data;
        w_bin_index   = r_bin_index;
        w_error       = 1'b0;
        w_error_code  = r_error_code;
        if (w_rx_err) begin
            w_error      = 1'b1;
            w_error_code = ERR_FRAMING;
        end else if (w_rx_valid && w_rx_byte[7]) begin
            case (w_rx_byte)
                CTRL_FRAME_START: begin
                    w_frame_start = 1'b1;
                    w_bin_cnt     = '0;
                    w_state       = ST_FRAME;
                    if (r_state == ST_BIN) begin
                        w_error      = 1'b1;
                        w_error_code = ERR_PROTOCOL;
                    end else begin
                        w_error      = 1'b0;
                    end
                end
                CTRL_FRAME_END: begin
                    case (r_state)
                        ST_FRAME: begin
                            w_frame_end  = 1'b1;
                            w_frame_bins = r_bin_cnt;
                            w_state      = ST_IDLE;
                        end
                        ST_BIN: begin
                            w_error      = 1'b1;
                            w_error_code = ERR_PROTOCOL;
                            w_frame_end  = 1'b1;
                            w_frame_bins = r_bin_cnt;
                            w_state      = ST_IDLE;
                        end
                        default: begin
                            w_state = r_state;
                        end
                    endcase
                end
                CTRL_BIN_START: begin
                    case (r_state)
                        ST_FRAME: begin
                            w_acc    = '0;
                            w_groups = 3'd0;
                            w_state  = ST_BIN;
                        end
                        ST_BIN: begin
                            w_error      = 1'b1;
                            w_error_code = ERR_PROTOCOL;
                            w_acc        = '0;
                            w_groups     = 3'd0;
                        end
                        default: begin
                            w_error      = 1'b1;
                            w_error_code = ERR_PROTOCOL;
                        end
                    endcase
                end
                CTRL_BIN_END: begin
                    if (r_state == ST_BIN) begin
                        w_bin_valid = 1'b1;
                        w_bin_data  = r_acc;
                        w_bin_index = r_bin_cnt;
                        w_bin_cnt   = (r_bin_cnt == {BIN_CNT_W{1'b1}}) ?
                                      r_bin_cnt : r_bin_cnt + BIN_CNT_W'(1);
                        w_state     = ST_FRAME;
                    end else begin
                        w_error      = 1'b1;
                        w_error_code = ERR_PROTOCOL;
                    end
                end
                default: begin
                    w_error      = 1'b1;
                    w_error_code = ERR_PROTOCOL;
                end
            endcase
        end else if (w_rx_valid) begin
            if (r_state != ST_BIN) begin
                w_error      = 1'b1;
                w_error_code = ERR_PROTOCOL;
            end else if (w_overflow) begin
                w_error      = 1'b1;
                w_error_code = ERR_OVERFLOW;
                w_state      = ST_FRAME;
            end else begin
                w_acc    = place_group(r_acc, w_rx_byte[6:0], r_groups);
                w_groups = r_groups + 3'd1;
            end
        end else begin
            w_state = r_state;
        end
    end

    assign o_frame_start = r_frame_start;
    assign o_frame_end   = r_frame_end;
    assign o_frame_bins  = r_frame_bins;
    assign o_bin_valid   = r_bin_valid;
    assign o_bin_data    = r_bin_data;
    assign o_bin_index   = r_bin_index;
    assign o_error       = r_error;
    assign o_error_code  = r_error_code;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench: serialises directed and random byte streams onto the
// line and compares decoder events against a protocol-level reference model.
`timescale 1ns/1ps
module tb_uart_frame_decoder;

    localparam int CPB = 8;
    localparam int BCW = 10;

    logic           sys_clock = 1'b0;
    logic           reset     = 1'b1;
    logic           UART_RX   = 1'b1;
    logic           o_frame_start;
    logic           o_frame_end;
    logic [BCW-1:0] o_frame_bins;
    logic           o_bin_valid;
    logic [21:0]    o_bin_data;
    logic [BCW-1:0] o_bin_index;
    logic           o_error;
    logic [1:0]     o_error_code;

    uart_frame_decoder #(.CLKS_PER_BIT(CPB), .BIN_CNT_W(BCW)) dut (
        .sys_clock     (sys_clock),
        .reset         (reset),
        .UART_RX       (UART_RX),
        .o_frame_start (o_frame_start),
        .o_frame_end   (o_frame_end),
        .o_frame_bins  (o_frame_bins),
        .o_bin_valid   (o_bin_valid),
        .o_bin_data    (o_bin_data),
        .o_bin_index   (o_bin_index),
        .o_error       (o_error),
        .o_error_code  (o_error_code)
    );

    always #5 sys_clock = ~sys_clock;

    int n_checks = 0;
    int n_errors = 0;

    // Observed events, sampled on the falling edge.
    int          obs_fs = 0;
    logic [31:0] obs_fe[$];
    logic [31:0] obs_bin[$];
    logic [31:0] obs_err[$];

    always @(negedge sys_clock) begin
        if (!reset) begin
            if (o_frame_start) obs_fs++;
            if (o_frame_end)   obs_fe.push_back(32'(o_frame_bins));
            if (o_bin_valid)   obs_bin.push_back({o_bin_index, o_bin_data});
            if (o_error)       obs_err.push_back(32'(o_error_code));
        end
    end

    // Reference model: mode 0 idle, 1 in frame, 2 in bin.
    int          m_mode = 0;
    int          m_bins = 0;
    int          m_groups[$];
    int          exp_fs = 0;
    logic [31:0] exp_fe[$];
    logic [31:0] exp_bin[$];
    logic [31:0] exp_err[$];

    task automatic model_reset();
        m_mode = 0;
        m_bins = 0;
        m_groups.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        longint unsigned v;
        if (!stop_ok) begin
            exp_err.push_back(32'd0);
        end else if (b == 8'h80) begin
            exp_fs++;
            if (m_mode == 2) exp_err.push_back(32'd2);
            m_bins = 0;
            m_mode = 1;
        end else if (b == 8'h81) begin
            if (m_mode != 0) begin
                if (m_mode == 2) exp_err.push_back(32'd2);
                exp_fe.push_back(32'(m_bins));
                m_mode = 0;
            end
        end else if (b == 8'h82) begin
            if (m_mode == 0) exp_err.push_back(32'd2);
            else begin
                if (m_mode == 2) exp_err.push_back(32'd2);
                m_groups.delete();
                m_mode = 2;
            end
        end else if (b == 8'h83) begin
            if (m_mode == 2) begin
                v = 0;
                foreach (m_groups[i]) v += longint'(m_groups[i]) * (longint'(1) << (7 * i));
                exp_bin.push_back({10'(m_bins), 22'(v)});
                if (m_bins < 1023) m_bins++;
                m_mode = 1;
            end else begin
                exp_err.push_back(32'd2);
            end
        end else if (b[7]) begin
            exp_err.push_back(32'd2);
        end else if (m_mode != 2) begin
            exp_err.push_back(32'd2);
        end else if (m_groups.size() >= 4 || (m_groups.size() == 3 && b > 8'd1)) begin
            exp_err.push_back(32'd1);
            m_mode = 1;
        end else begin
            m_groups.push_back(int'(b));
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " frame_start count"}, 32'(obs_fs), 32'(exp_fs));
        chk({tag, " frame_end count"}, 32'(obs_fe.size()), 32'(exp_fe.size()));
        chk({tag, " bin count"}, 32'(obs_bin.size()), 32'(exp_bin.size()));
        chk({tag, " error count"}, 32'(obs_err.size()), 32'(exp_err.size()));
        while (obs_fe.size() > 0 && exp_fe.size() > 0)
            chk({tag, " frame_bins"}, obs_fe.pop_front(), exp_fe.pop_front());
        while (obs_bin.size() > 0 && exp_bin.size() > 0)
            chk({tag, " bin index/data"}, obs_bin.pop_front(), exp_bin.pop_front());
        while (obs_err.size() > 0 && exp_err.size() > 0)
            chk({tag, " error code"}, obs_err.pop_front(), exp_err.pop_front());
        obs_fs = 0; exp_fs = 0;
        obs_fe.delete(); exp_fe.delete();
        obs_bin.delete(); exp_bin.delete();
        obs_err.delete(); exp_err.delete();
    endtask

    task automatic bit_time(input logic level);
        UART_RX = level;
        repeat (CPB) @(posedge sys_clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_ok ? 1'b1 : 1'b0);
        bit_time(1'b1);
        repeat ($urandom_range(0, 5)) @(posedge sys_clock);
        model_byte(b, stop_ok);
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " o_frame_start"}, 32'(o_frame_start), 32'd0);
        chk({tag, " o_frame_end"},   32'(o_frame_end),   32'd0);
        chk({tag, " o_frame_bins"},  32'(o_frame_bins),  32'd0);
        chk({tag, " o_bin_valid"},   32'(o_bin_valid),   32'd0);
        chk({tag, " o_bin_data"},    32'(o_bin_data),    32'd0);
        chk({tag, " o_bin_index"},   32'(o_bin_index),   32'd0);
        chk({tag, " o_error"},       32'(o_error),       32'd0);
        chk({tag, " o_error_code"},  32'(o_error_code),  32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] b;
        int         r;
        int         k;

        repeat (5) @(posedge sys_clock);
        @(negedge sys_clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (3 * CPB) @(posedge sys_clock);

        send_seq('{8'h80, 8'h82, 8'h05, 8'h83, 8'h81});
        check_all("single bin");

        send_seq('{8'h80, 8'h82, 8'h7F, 8'h7F, 8'h7F, 8'h01, 8'h83});
        send_seq('{8'h82, 8'h7F, 8'h7F, 8'h7F, 8'h02, 8'h83, 8'h81});
        check_all("full width and group3 overflow");

        send_seq('{8'h80, 8'h82, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h83, 8'h81});
        check_all("fifth group overflow");

        send_byte(8'h80);
        send_byte(8'h82, 1'b0);
        send_seq('{8'h82, 8'h83, 8'h81});
        check_all("framing error");

        send_seq('{8'h80, 8'h82, 8'h05, 8'h80, 8'h82, 8'h33, 8'h83, 8'h81});
        check_all("restart in bin");

        send_seq('{8'h05, 8'h83, 8'h81, 8'h82, 8'h9A, 8'hFF, 8'h80, 8'h83, 8'h44, 8'h81});
        check_all("protocol errors");

        // Abort a byte at bit 4 with reset asserted, then decode a fresh frame.
        send_seq('{8'h80, 8'h82, 8'h2A, 8'h83});
        check_all("before reset");
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b0);
        reset = 1'b1;
        repeat (2) @(posedge sys_clock);
        @(negedge sys_clock);
        check_reset_outputs("mid-byte reset");
        UART_RX = 1'b1;
        repeat (CPB) @(posedge sys_clock);
        reset = 1'b0;
        model_reset();
        repeat (2 * CPB) @(posedge sys_clock);
        send_seq('{8'h80, 8'h82, 8'h11, 8'h22, 8'h83, 8'h82, 8'h83, 8'h81});
        check_all("after reset");

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                send_byte(8'h82);
                k = $urandom_range(0, 5);
                for (int g = 0; g < k; g++) begin
                    if ($urandom_range(0, 2) == 0) b = 8'($urandom_range(0, 2));
                    else                           b = 8'($urandom_range(0, 127));
                    send_byte(b);
                end
                send_byte(8'h83);
            end else if (r < 55) begin
                send_byte(8'($urandom_range(0, 127)));
            end else if (r < 85) begin
                send_byte(8'(8'h80 + $urandom_range(0, 3)));
            end else if (r < 93) begin
                send_byte(8'($urandom_range(132, 255)));
            end else begin
                send_byte(8'($urandom_range(0, 255)), 1'b0);
            end
            if (it % 10 == 9) check_all("random");
        end
        send_byte(8'h81);
        check_all("random tail");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, gives sys_clock cycles per UART bit (8N1 line format).
REQ-002 Parameter BIN_CNT_W, default 10, gives the width of the bin counter.
REQ-003 sys_clock  in  1  the single clock; all state is clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 UART_RX  in  1  serial line, idle high, asynchronous to sys_clock.
REQ-006 o_frame_start  out  1  one-cycle pulse when FRAME_START is accepted.
REQ-007 o_frame_end  out  1  one-cycle pulse when a frame closes.
REQ-008 o_frame_bins  out  BIN_CNT_W  count of bins completed in the closing frame; valid with o_frame_end.
REQ-009 o_bin_valid  out  1  one-cycle pulse when a bin completes.
REQ-010 o_bin_data  out  22  decoded bin value; valid with o_bin_valid.
REQ-011 o_bin_index  out  BIN_CNT_W  zero-based position of the bin within its frame; valid with o_bin_valid.
REQ-012 o_error  out  1  one-cycle error pulse.
REQ-013 o_error_code  out  2  error class: 0 framing, 1 overflow, 2 protocol; valid with o_error.

Function
REQ-014 UART_RX shall pass through a 2-flop synchronizer before any use.
REQ-015 Byte receiver:
- start detected on a falling edge, confirmed low at the half-bit point
- 8 data bits, LSB first, each sampled at mid-bit
- stop bit sampled at mid-bit
- byte-valid strobe asserted for exactly one cycle.
REQ-016 A stop bit sampled low shall raise o_error with code 0, discard the byte, and leave decoder state unchanged.
REQ-017 Byte classes: bit7=1 is a control byte; bit7=0 is a data byte carrying a 7-bit payload.
REQ-018 Control codes: 0x80 FRAME_START, 0x81 FRAME_END, 0x82 BIN_START, 0x83 BIN_END; 0x84-0xFF are undefined.
REQ-019 Decoder state machine: IDLE, FRAME, BIN; reset state is IDLE.
REQ-020 FRAME_START, from any state:
- pulse o_frame_start
- clear the bin counter
- go to FRAME
- raise protocol error only if the state was BIN; the partial bin is dropped.
REQ-021 FRAME_END:
- in FRAME: pulse o_frame_end with o_frame_bins = bin count, go to IDLE.
- in BIN: raise protocol error, drop the bin, pulse o_frame_end, go to IDLE.
- in IDLE: ignore, no error.
REQ-022 BIN_START:
- in FRAME: clear accumulator and group count, go to BIN.
- in BIN: raise protocol error, clear accumulator, stay in BIN.
- in IDLE: raise protocol error, ignore.
REQ-023 Data byte in BIN: group k (k = 0..3, arrival order) fills o_bin_data bits [7k+6:7k], truncated at bit 21.
REQ-024 Overflow: a 5th group, or group 3 with payload > 0x01, shall raise o_error code 1, drop the bin, and go to FRAME.
REQ-025 BIN_END in BIN:
- o_bin_valid pulses the cycle after the BIN_END byte strobe
- o_bin_index = bin count before increment
- bin count increments, saturating at all-ones
- go to FRAME.
REQ-026 A bin with zero data groups shall complete with value 0.
REQ-027 Protocol error (code 2) without state change for:
- data byte in IDLE or FRAME
- BIN_END in IDLE or FRAME
- any undefined control code.
REQ-028 Output timing: all pulses are registered, at most one error per received byte, and error and bin/frame pulses may coincide.

Reset
REQ-029 Reset shall force:
- all pulse outputs to 0
- o_bin_data, o_bin_index, o_frame_bins, o_error_code to 0
- the state machine to IDLE
- the byte receiver to idle.
REQ-030 Reset mid-byte shall abandon that byte; after release, the receiver waits for line-high before arming start detection.

Structure
REQ-031 Package uart_frame_pkg shall hold the control-code constants, DATA_W=22, GROUP_W=7, MAX_GROUPS=4, and the error-code enum.
REQ-032 Sub-module uart_rx_byte shall implement REQ-014 to REQ-016 (line to byte, with a framing-error flag); uart_frame_decoder instantiates it once.

Verification
REQ-033 Bytes 80,82,05,83,81 -> o_frame_start; o_bin_valid with data 0x000005, index 0; o_frame_end with bins 1; no error.
REQ-034 Bytes 80,82,7F,7F,7F,01,83 -> o_bin_data 0x3FFFFF; same with last group 02 -> error code 1, no bin_valid, state FRAME.
REQ-035 80,82 then five 01 data bytes -> error code 1 on the fifth byte; a following 83 gives error code 2.
REQ-036 Byte 82 sent with stop bit low -> error code 0, no state change; a following correct 82 then 83 -> bin 0 of value 0.
REQ-037 80,82,05 then FRAME_START -> error code 2 plus o_frame_start; the next bin is reported with index 0.
REQ-038 Reset asserted at bit 4 of a byte -> all outputs 0; the next full frame decodes correctly.
